multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences one instruction over 3-5 cycles through a state machine that drives every datapath select and strobe: PC, IR, register file, ALU and the shared instruction/data memory port.
- Supports R-type, addi, lw, sw, beq and j, with a memory-ready handshake, a sticky illegal-opcode trap and a retired-instruction counter.
- Sits between the IR opcode field and the multi-cycle datapath.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALUOp width.
- ALUOP_ADD, 3'b000, ALUOp code for add.
- ALUOP_SUB, 3'b001, ALUOp code for subtract.
- ALUOP_RTYPE, 3'b111, ALUOp code meaning "decode funct".
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- Op_i  in  OP_W  opcode from IR; stable from DECODE until the instruction retires.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- RegDst_o  out  1  1 selects rd, 0 selects rt.
- MemtoReg_o  out  1  writeback data from MDR.
- RegWrite_o  out  1  register file write enable.
- ALUSrcA_o  out  1  0 selects PC, 1 selects A.
- ALUSrcB_o  out  2  00 selects B, 01 selects 4, 10 selects sign-extended imm, 11 selects imm<<2.
- ALUOp_o  out  ALUOP_W  ALU operation.
- MemRead_o  out  1  memory read request.
- MemWrite_o  out  1  memory write request.
- IorD_o  out  1  0 selects PC address, 1 selects ALUOut address.
- IRWrite_o  out  1  IR load.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if ALU zero.
- PCSource_o  out  2  00 selects ALU, 01 selects ALUOut, 10 selects jump target.
- state_o  out  4  current state (debug).
- illegal_o  out  1  sticky illegal-opcode flag.
- instr_cnt_o  out  CNT_W  retired instruction count.

Behaviour:
Reset and defaults:
- Reset is synchronous on rst_i. It sets state to FETCH, illegal_o to 0 and instr_cnt_o to 0.
- While rst_i is high, every strobe and select output is forced to 0.
- Unlisted outputs in any state are 0. Outputs are decoded from the registered state.
- IRWrite_o and PCWrite_o in FETCH additionally depend on mem_ready_i.

Opcodes:
- R 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
- All other opcodes are illegal.

States (encoding in parentheses):
- FETCH(0): MemRead=1, IorD=0, SrcA=0, SrcB=01, ALUOp=ADD, PCSource=00. IRWrite and PCWrite equal mem_ready_i. Stay in FETCH while mem_ready_i=0; go to DECODE when it is 1.
- DECODE(1): SrcA=0, SrcB=11, ALUOp=ADD. Next state: lw/sw go to MEMADR, R goes to RTEXEC, addi to IEXEC, beq to BRANCH, j to JUMP, anything else to TRAP.
- MEMADR(2): SrcA=1, SrcB=10, ADD. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD(3): MemRead=1, IorD=1. Hold until mem_ready_i, then go to MEMWB.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Retire and go to FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Hold until mem_ready_i, then retire and go to FETCH.
- RTEXEC(6): SrcA=1, SrcB=00, ALUOp=RTYPE. Go to ALUWB.
- IEXEC(7): SrcA=1, SrcB=10, ADD. Go to ALUWB.
- ALUWB(8): RegWrite=1, MemtoReg=0, RegDst=(Op_i==R). Retire and go to FETCH.
- BRANCH(9): SrcA=1, SrcB=00, SUB, PCWriteCond=1, PCSource=01. Retire and go to FETCH.
- JUMP(10): PCWrite=1, PCSource=10. Retire and go to FETCH.
- TRAP(11): all strobes 0, illegal_o=1. Stays in TRAP until rst_i. Not counted as retired.
- Encodings 12-15 are unreachable. If entered, the block goes to TRAP next cycle.

Retire and counter:
- "Retire" means instr_cnt_o increments by 1 on the transition edge out of that state.
- instr_cnt_o wraps modulo 2^CNT_W without any flag.

Latency:
- mem_ready_i asserted immediately in every memory state gives: lw 5 cycles; sw, R and addi 4 cycles; beq and j 3 cycles.
- Each cycle of mem_ready_i=0 in a memory state adds 1 cycle.

Handshake:
- MemRead/MemWrite are held constant until the ready cycle.
- mem_ready_i outside FETCH, MEMRD and MEMWR is ignored.
- No write strobe fires twice per instruction.

Reset mid-operation:
- rst_i in any state, including a stalled memory state, returns the block to FETCH next cycle with no strobes during the reset cycle.

Test Plan:
- Reset then R-type, mem_ready_i tied 1 -> state sequence 0,1,6,8,0; RegDst=1 and RegWrite=1 in ALUWB; instr_cnt_o=1.
- lw with mem_ready_i low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0 (8 cycles); MemRead/IorD=1 held throughout MEMRD; MemtoReg=1 in MEMWB.
- sw, then beq, then j back-to-back with ready=1 -> MemWrite pulses exactly once; PCWriteCond=1 with ALUOp=001 in BRANCH; PCWrite=1 with PCSource=10 in JUMP; instr_cnt_o=3 after 11 cycles.
- FETCH with mem_ready_i=0 for 3 cycles -> IRWrite/PCWrite stay 0; both pulse exactly in the ready cycle.
- Opcode 111111 -> TRAP at cycle 2; illegal_o=1; all strobes 0 for 20 cycles; rst_i clears illegal_o and returns to FETCH.
- rst_i asserted in MEMWR while stalled; CNT_W=4 with 17 addi -> MemWrite drops in the reset cycle, then FETCH; counter reads 1 after wrap.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences one instruction through FETCH..writeback and
// drives every datapath select/strobe, plus a sticky illegal-opcode flag and retire counter.
module multicycle_control #(
    parameter int                   OP_W        = 6,
    parameter int                   ALUOP_W     = 3,
    parameter logic [ALUOP_W-1:0]   ALUOP_ADD   = 3'b000,
    parameter logic [ALUOP_W-1:0]   ALUOP_SUB   = 3'b001,
    parameter logic [ALUOP_W-1:0]   ALUOP_RTYPE = 3'b111,
    parameter int                   CNT_W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic               mem_ready_i,
    output logic               RegDst_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IorD_o,
    output logic               IRWrite_o,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic [1:0]         PCSource_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_IEXEC  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    state_t             state_q;
    state_t             state_next;
    logic               retire;
    logic               illegal_q;
    logic [CNT_W-1:0]   cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_next;
            if (state_next == S_TRAP)
                illegal_q <= 1'b1;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // NOTE: defaults at the top of every combinational block keep each output
    // assigned on all paths, so no latches are inferred.
    always_comb begin
        state_next = state_q;
        retire     = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_next = S_DECODE;
            S_DECODE: begin
                case (Op_i)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_RTEXEC;
                    OP_ADDI:      state_next = S_IEXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready_i) state_next = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready_i) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_RTEXEC, S_IEXEC: state_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:   state_next = S_TRAP;
            // Encodings 12-15 can only come from an upset; park in TRAP.
            default:  state_next = S_TRAP;
        endcase
    end

    always_comb begin
        RegDst_o      = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = ALUOP_ADD;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IorD_o        = 1'b0;
        IRWrite_o     = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = 2'b00;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    MemRead_o = 1'b1;
                    ALUSrcB_o = 2'b01;
                    IRWrite_o = mem_ready_i;
                    PCWrite_o = mem_ready_i;
                end
                S_DECODE: ALUSrcB_o = 2'b11;
                S_MEMADR, S_IEXEC: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                end
                S_MEMRD: begin
                    MemRead_o = 1'b1;
                    IorD_o    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg_o = 1'b1;
                    RegWrite_o = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite_o = 1'b1;
                    IorD_o     = 1'b1;
                end
                S_RTEXEC: begin
                    ALUSrcA_o = 1'b1;
                    ALUOp_o   = ALUOP_RTYPE;
                end
                S_ALUWB: begin
                    RegWrite_o = 1'b1;
                    RegDst_o   = (Op_i == OP_R);
                end
                S_BRANCH: begin
                    ALUSrcA_o     = 1'b1;
                    ALUOp_o       = ALUOP_SUB;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite_o  = 1'b1;
                    PCSource_o = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state_o     = state_q;
    assign illegal_o   = illegal_q;
    assign instr_cnt_o = cnt_q;

endmodule
